// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch dispatcher: opcodes, FSM encoding and the
// packed command layout carried through the command queue.
package fetch_pkg;

    localparam logic [7:0] FETCH_OP_FEATURE = 8'h01;
    localparam logic [7:0] FETCH_OP_WEIGHT  = 8'h02;
    localparam logic [7:0] FETCH_OP_SCALER  = 8'h03;

    localparam int FETCH_CMD_W = 56;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_t;

    // Field order is also the bit order of a queue entry, opcode in the MSBs.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  fetch_type;
        logic [15:0] src_addr;
        logic [7:0]  dst_addr;
        logic [7:0]  mem_sel;
        logic [7:0]  fetch_counter;
    } fetch_cmd_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == FETCH_OP_FEATURE) || (op == FETCH_OP_WEIGHT) || (op == FETCH_OP_SCALER);
    endfunction

endpackage

// File: rtl/fetch_cmd_fifo.sv
// Synchronous first-word-fall-through command queue with full/empty/level.
// Writes to a full queue and reads from an empty one are ignored.
module fetch_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 56
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: storage is deliberately left unreset; pointers and count define
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/fetch_dispatch_ctrl.sv
// Queues parser fetch commands and issues them one at a time to the feature or
// weight/scaler fetch unit. Optional WAIT watchdog enabled by FETCH_TIMEOUT_EN.
module fetch_dispatch_ctrl
    import fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [7:0]  cmd_fetch_type,
    input  logic [15:0] cmd_src_addr,
    input  logic [7:0]  cmd_dst_addr,
    input  logic [7:0]  cmd_mem_sel,
    input  logic [7:0]  cmd_fetch_counter,
    output logic        feature_fetch_enable,
    output logic        weight_fetch_enable,
    output logic        scaler_fetch_enable,
    output logic [7:0]  fetch_type,
    output logic [15:0] src_addr,
    output logic [7:0]  dst_addr,
    output logic [7:0]  mem_sel,
    output logic [7:0]  fetch_counter,
    input  logic        feature_fetch_done,
    input  logic        weight_fetch_done,
    output logic        busy,
    output logic        idle,
    output logic        illegal_op,
    output logic        timeout_err
);

    fetch_state_t                   state;
    fetch_state_t                   state_nxt;
    fetch_cmd_t                     in_cmd;
    fetch_cmd_t                     head_cmd;
    fetch_cmd_t                     cur_cmd;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           push;
    logic                           pop;
    logic                           done_match;
    logic                           timeout_hit;
    logic [$clog2(QUEUE_DEPTH):0]   unused_level;

    assign in_cmd = {cmd_opcode, cmd_fetch_type, cmd_src_addr,
                     cmd_dst_addr, cmd_mem_sel, cmd_fetch_counter};

    // Illegal opcodes are consumed (handshake completes) but never queued.
    assign push = cmd_valid && cmd_ready && is_legal_op(cmd_opcode);
    assign pop  = (state == ST_IDLE) && !fifo_empty;

    fetch_cmd_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (FETCH_CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (in_cmd),
        .rd_en   (pop),
        .rd_data (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (unused_level)
    );

    assign done_match = (cur_cmd.opcode == FETCH_OP_FEATURE) ? feature_fetch_done
                                                              : weight_fetch_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_cmd <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cur_cmd <= head_cmd;
            end
        end
    end

    // NOTE: next-state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (done_match || timeout_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (cmd_valid && cmd_ready && !is_legal_op(cmd_opcode)) begin
            illegal_op <= 1'b1;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        timeout_q;

    // Fires in the last permitted WAIT cycle unless the matching done arrives.
    assign timeout_hit = (state == ST_WAIT) && !done_match &&
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    assign feature_fetch_enable = (state == ST_ISSUE) && (cur_cmd.opcode == FETCH_OP_FEATURE);
    assign weight_fetch_enable  = (state == ST_ISSUE) && (cur_cmd.opcode == FETCH_OP_WEIGHT);
    assign scaler_fetch_enable  = (state == ST_ISSUE) && (cur_cmd.opcode == FETCH_OP_SCALER);

    assign fetch_type    = cur_cmd.fetch_type;
    assign src_addr      = cur_cmd.src_addr;
    assign dst_addr      = cur_cmd.dst_addr;
    assign mem_sel       = cur_cmd.mem_sel;
    assign fetch_counter = cur_cmd.fetch_counter;

    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE);
    assign idle      = (state == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// Directed self-checking bench for fetch_dispatch_ctrl; the watchdog section
// is exercised when built with FETCH_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_fetch_dispatch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [7:0]  cmd_fetch_type;
    logic [15:0] cmd_src_addr;
    logic [7:0]  cmd_dst_addr;
    logic [7:0]  cmd_mem_sel;
    logic [7:0]  cmd_fetch_counter;
    logic        feature_fetch_enable;
    logic        weight_fetch_enable;
    logic        scaler_fetch_enable;
    logic [7:0]  fetch_type;
    logic [15:0] src_addr;
    logic [7:0]  dst_addr;
    logic [7:0]  mem_sel;
    logic [7:0]  fetch_counter;
    logic        feature_fetch_done;
    logic        weight_fetch_done;
    logic        busy;
    logic        idle;
    logic        illegal_op;
    logic        timeout_err;

    logic [2:0]  ens;
    logic [47:0] fields;

    int vectors     = 0;
    int miscompares = 0;

    fetch_dispatch_ctrl #(
        .QUEUE_DEPTH    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_opcode           (cmd_opcode),
        .cmd_fetch_type       (cmd_fetch_type),
        .cmd_src_addr         (cmd_src_addr),
        .cmd_dst_addr         (cmd_dst_addr),
        .cmd_mem_sel          (cmd_mem_sel),
        .cmd_fetch_counter    (cmd_fetch_counter),
        .feature_fetch_enable (feature_fetch_enable),
        .weight_fetch_enable  (weight_fetch_enable),
        .scaler_fetch_enable  (scaler_fetch_enable),
        .fetch_type           (fetch_type),
        .src_addr             (src_addr),
        .dst_addr             (dst_addr),
        .mem_sel              (mem_sel),
        .fetch_counter        (fetch_counter),
        .feature_fetch_done   (feature_fetch_done),
        .weight_fetch_done    (weight_fetch_done),
        .busy                 (busy),
        .idle                 (idle),
        .illegal_op           (illegal_op),
        .timeout_err          (timeout_err)
    );

    always #5 clk = ~clk;

    assign ens    = {feature_fetch_enable, weight_fetch_enable, scaler_fetch_enable};
    assign fields = {fetch_type, src_addr, dst_addr, mem_sel, fetch_counter};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are then sampled 1ns after the edge. A command that
    // was presented with cmd_ready high is retired from the bus.
    task automatic step();
        logic acc;
        acc = cmd_valid && cmd_ready;
        @(posedge clk);
        #1;
        if (acc) cmd_valid = 1'b0;
    endtask

    task automatic present(input logic [7:0] op, input logic [7:0] ft, input logic [15:0] src,
                           input logic [7:0] dst, input logic [7:0] sel, input logic [7:0] cnt);
        cmd_opcode        = op;
        cmd_fetch_type    = ft;
        cmd_src_addr      = src;
        cmd_dst_addr      = dst;
        cmd_mem_sel       = sel;
        cmd_fetch_counter = cnt;
        cmd_valid         = 1'b1;
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] ft, input logic [15:0] src,
                        input logic [7:0] dst, input logic [7:0] sel, input logic [7:0] cnt);
        present(op, ft, src, dst, sel, cnt);
        step();
    endtask

    task automatic pulse_done(input logic feat, input logic wgt);
        feature_fetch_done = feat;
        weight_fetch_done  = wgt;
        step();
        feature_fetch_done = 1'b0;
        weight_fetch_done  = 1'b0;
    endtask

    // Bounded wait for a given enable pattern; expiry shows up as a miscompare.
    task automatic wait_en(input string tag, input logic [2:0] pattern, input int max_steps);
        int n = 0;
        while (ens !== pattern && n < max_steps) begin
            step();
            n++;
        end
        check(tag, ens, pattern);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_idle"}, idle, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_enables"}, ens, 0);
        check({tag, "_fields"}, fields, 0);
        check({tag, "_illegal_op"}, illegal_op, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        rst                = 1'b1;
        cmd_valid          = 1'b0;
        cmd_opcode         = '0;
        cmd_fetch_type     = '0;
        cmd_src_addr       = '0;
        cmd_dst_addr       = '0;
        cmd_mem_sel        = '0;
        cmd_fetch_counter  = '0;
        feature_fetch_done = 1'b0;
        weight_fetch_done  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_hold");
        rst = 1'b0;
        step();
        check_reset("reset_release");

        // Single feature command: enable two cycles after presentation.
        push(FETCH_OP_FEATURE, 8'h05, 16'h0040, 8'h10, 8'h01, 8'd20);
        check("t1_queued_no_enable", ens, 3'b000);
        check("t1_idle_low", idle, 0);
        step();
        check("t1_feature_enable", ens, 3'b100);
        check("t1_fields", fields, {8'h05, 16'h0040, 8'h10, 8'h01, 8'd20});
        check("t1_busy_issue", busy, 1);
        step();
        check("t1_single_pulse", ens, 3'b000);
        pulse_done(1'b0, 1'b1);
        check("t1_wrong_done_ignored", busy, 1);
        step();
        pulse_done(1'b1, 1'b0);
        check("t1_done_busy", busy, 0);
        check("t1_done_idle", idle, 1);
        check("t1_fields_held", fields, {8'h05, 16'h0040, 8'h10, 8'h01, 8'd20});
        pulse_done(1'b1, 1'b1);
        check("t1_stray_done_idle", idle, 1);
        check("t1_stray_done_enables", ens, 3'b000);

        // Weight then scaler back to back; foreign done while waiting on weight.
        push(FETCH_OP_WEIGHT, 8'h01, 16'h0100, 8'h20, 8'h00, 8'd8);
        push(FETCH_OP_SCALER, 8'h02, 16'h0200, 8'h30, 8'h00, 8'd4);
        check("t2_weight_enable", ens, 3'b010);
        check("t2_weight_src", src_addr, 16'h0100);
        step();
        pulse_done(1'b1, 1'b0);
        check("t2_feature_done_ignored", busy, 1);
        check("t2_no_early_scaler", ens, 3'b000);
        pulse_done(1'b0, 1'b1);
        check("t2_gap_enables", ens, 3'b000);
        check("t2_gap_busy", busy, 0);
        step();
        check("t2_scaler_enable", ens, 3'b001);
        check("t2_scaler_fields", fields, {8'h02, 16'h0200, 8'h30, 8'h00, 8'd4});
        step();
        pulse_done(1'b0, 1'b1);
        check("t2_final_idle", idle, 1);

        // Fill the queue behind an in-flight command, then hold a sixth.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_ready_before_%0d", i), cmd_ready, 1);
            push(FETCH_OP_FEATURE, 8'h00, 16'h1000 + 16'(i), 8'(i), 8'h00, 8'd1);
            if (i == 1) begin
                check("t3_first_enable", ens, 3'b100);
                check("t3_first_src", src_addr, 16'h1000);
            end
        end
        check("t3_full_not_ready", cmd_ready, 0);
        present(FETCH_OP_FEATURE, 8'h00, 16'h1005, 8'h05, 8'h00, 8'd1);
        repeat (3) step();
        check("t3_held_not_ready", cmd_ready, 0);
        check("t3_held_no_enable", ens, 3'b000);
        for (int k = 1; k < 6; k++) begin
            pulse_done(1'b1, 1'b0);
            wait_en($sformatf("t3_enable_%0d", k), 3'b100, 8);
            check($sformatf("t3_src_%0d", k), src_addr, 16'h1000 + 16'(k));
            step();
        end
        pulse_done(1'b1, 1'b0);
        check("t3_drained_idle", idle, 1);

        // Illegal opcode is dropped and flagged; the next command is unaffected.
        push(8'h07, 8'h00, 16'hDEAD, 8'h00, 8'h00, 8'd1);
        check("t4_illegal_flag", illegal_op, 1);
        check("t4_illegal_not_queued", idle, 1);
        step();
        check("t4_no_enable", ens, 3'b000);
        push(FETCH_OP_WEIGHT, 8'h03, 16'h0ABC, 8'h44, 8'h00, 8'd2);
        step();
        check("t4_next_weight_enable", ens, 3'b010);
        check("t4_next_weight_src", src_addr, 16'h0ABC);
        step();
        pulse_done(1'b0, 1'b1);
        check("t4_illegal_sticky", illegal_op, 1);
        check("t4_idle", idle, 1);

`ifdef FETCH_TIMEOUT_EN
        check("t5_no_timeout_yet", timeout_err, 0);
        push(FETCH_OP_FEATURE, 8'h00, 16'h0055, 8'h00, 8'h00, 8'd1);
        step();
        check("t5_enable", ens, 3'b100);
        repeat (16) step();
        check("t5_wait_16_busy", busy, 1);
        check("t5_wait_16_no_err", timeout_err, 0);
        step();
        check("t5_timeout_err", timeout_err, 1);
        check("t5_abandoned_idle", idle, 1);
        push(FETCH_OP_SCALER, 8'h00, 16'h0066, 8'h00, 8'h00, 8'd1);
        step();
        check("t5_next_scaler_enable", ens, 3'b001);
`else
        check("t5_timeout_tied_low", timeout_err, 0);
        push(FETCH_OP_FEATURE, 8'h00, 16'h0077, 8'h00, 8'h00, 8'd1);
        step();
        check("t5_enable", ens, 3'b100);
`endif

        // Asynchronous reset while waiting with a command still queued.
        step();
        push(FETCH_OP_WEIGHT, 8'h00, 16'h0088, 8'h00, 8'h00, 8'd1);
        check("t6_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check_reset("t6_rst_mid_wait");
        rst = 1'b0;
        repeat (3) step();
        check("t6_queue_flushed_idle", idle, 1);
        check("t6_queue_flushed_enables", ens, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
